frog_ctrl: RTL and testbench
============================

# frog_ctrl

Frame-synchronous game controller for the frog-crossing display. It turns debounced button presses into tile-sized frog moves and evaluates hazards and home-row arrivals once per video frame. It tracks lives, filled homes and score, and sequences the game through idle, play, dying, won and game-over states. It sits between the button debouncers, the VGA controller's frame tick and the collision logic upstream, and the pixel generator downstream, which draws the frog and filled homes from this block's registered outputs.

## Interface
- TILE, 32, frog step and sprite size in pixels
- START_COL, 9, respawn column (x = 32 + 32*col)
- LIVES, 3, lives loaded at game start
- DEATH_FRAMES, 60, refresh ticks spent in DYING
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high; all state returns to reset values on the next clock edge
- refresh_tick  in  1  one-cycle pulse per frame, asserted at start of vertical blank
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced level inputs
- hazard  in  1  frog overlaps a car or unsupported water; valid on refresh_tick cycles
- frog_x  out  10  frog top-left x; reset 320
- frog_y  out  10  frog top-left y; reset 420
- homes_filled  out  5  bit i set means home i (x = 32 + 128*i) is occupied; reset 0
- lives  out  2  remaining lives; reset LIVES
- score  out  8  saturating score; reset 0
- frog_dead  out  1  high in DYING; reset 0
- game_won  out  1  high in WON; reset 0
- game_over  out  1  high in OVER; reset 0

## Operation
- Grid mapping:
  - col 0..17 gives x = 32 + 32*col.
  - row 0..12 gives y = 36 + 32*row.
  - Start position is (START_COL, 12).
  - Row 0 is the home row. Home i covers cols 4i and 4i+1.
- Button handling:
  - A rising edge on any button is latched as one pending move.
  - Priority among simultaneous edges is up > down > left > right.
  - A later edge overwrites an unconsumed pending move.
  - Pending is cleared whenever the state is not PLAY.
- State IDLE (reset state):
  - Any button edge moves to PLAY.
  - On entry to PLAY: lives = LIVES, homes = 0, score = 0, frog at start.
- State PLAY, evaluated only on refresh_tick, in this order:
  1. If hazard = 1: lives -= 1, go to DYING, and discard the pending move.
  2. Else, if a move is pending, apply it. A move beyond col 0/17 or row 12 is ignored but still consumed.
  3. An up move adds 1 to score.
  4. If the frog lands on row 0 in home i with bit i clear: set bit i, add 10 to score, and respawn at start.
  5. If the frog lands on row 0 in a wall column or on an already-filled home: lives -= 1 and go to DYING.
  6. If homes_filled becomes 5'b11111, go to WON instead of respawning.
- State DYING:
  - The frog is frozen at the death position.
  - A frame counter counts DEATH_FRAMES refresh ticks.
  - When the count completes: if lives = 0, go to OVER; otherwise respawn at start and go to PLAY.
- States WON and OVER:
  - Hold all outputs.
  - Any button edge goes to IDLE.
- Arithmetic:
  - score saturates at 255.
  - lives never decrements below 0.
  - frog_x and frog_y are always computed from the registered col and row.

## Timing
- All outputs are registered.
- Output updates appear on the cycle after the refresh_tick cycle that caused them (1-cycle latency).
- A button edge in the same cycle as refresh_tick is not applied on that tick. It becomes pending for the next tick, and this overrides the clear-on-consume.
- Hazard and button edges on non-tick cycles never change position or lives.
- The DYING counter counts ticks, not clocks. It is cleared on entry, so dwell time is exactly DEATH_FRAMES ticks.
- Reset asserted mid-game or mid-DYING returns every output to its reset value on the next edge and discards any pending move.

## Test plan
- Reset, then a btn_up edge, then one tick -> state PLAY, frog (320, 420), lives 3. A second btn_up edge plus a tick -> frog_y 388, score 1.
- btn_left pressed repeatedly from col 0 -> frog_x stays 32, each move consumed, score unchanged.
- Walk up to row 0 at col 8 -> homes_filled 5'b00100, score +10, frog back at (320, 420). Repeat at col 8 -> death, lives 2, frog_dead high for exactly 60 ticks, then respawn.
- Hazard = 1 on a tick with an up move pending -> lives decrement, frog_y unchanged, move discarded. After three deaths -> game_over high, and a button edge returns the state to IDLE.
- Fill all five homes -> game_won high on the cycle after the fifth arrival. Score with many up moves clamps at 255.
- Button edge coincident with refresh_tick -> no move on that tick, move applied on the next tick. Reset asserted during DYING -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/frog_ctrl.sv
// Frame-synchronous frog-crossing game controller: button edges queue one move,
// and moves, hazards and home arrivals are resolved once per refresh_tick.
module frog_ctrl #(
    parameter int TILE         = 32,
    parameter int START_COL    = 9,
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 60
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       hazard,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [4:0] homes_filled,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       frog_dead,
    output logic       game_won,
    output logic       game_over
);
    localparam int               CNT_W    = $clog2(DEATH_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [9:0]       TILE_W   = 10'(TILE);
    localparam logic [4:0]       START_C  = 5'(START_COL);
    localparam logic [3:0]       START_R  = 4'd12;
    localparam logic [4:0]       LAST_COL = 5'd17;
    localparam logic [1:0]       LIVES_W  = 2'(LIVES);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_DYING, S_WON, S_OVER} state_e;
    typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_e;

    state_e           state_q, state_d;
    move_e            pend_q, pend_d, edge_mv_s;
    logic [4:0]       col_q, col_d, tgt_col_s;
    logic [3:0]       row_q, row_d, tgt_row_s;
    logic [1:0]       lives_q, lives_d;
    logic [4:0]       homes_q, homes_d, new_homes_s;
    logic [7:0]       score_q, score_d, sc_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       btn_q, btn_s, edge_s;
    logic [2:0]       hidx_s;
    logic             moved_s;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [1:0] dec_life(input logic [1:0] l);
        return (l == 2'd0) ? 2'd0 : l - 2'd1;
    endfunction

    assign btn_s  = {btn_up, btn_down, btn_left, btn_right};
    assign edge_s = btn_s & ~btn_q;

    // Resolve simultaneous button edges to a single move, up first.
    always_comb begin
        if (edge_s[3]) begin
            edge_mv_s = MV_UP;
        end else if (edge_s[2]) begin
            edge_mv_s = MV_DOWN;
        end else if (edge_s[1]) begin
            edge_mv_s = MV_LEFT;
        end else if (edge_s[0]) begin
            edge_mv_s = MV_RIGHT;
        end else begin
            edge_mv_s = MV_NONE;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= MV_NONE;
            col_q   <= START_C;
            row_q   <= START_R;
            lives_q <= LIVES_W;
            homes_q <= 5'd0;
            score_q <= 8'd0;
            cnt_q   <= '0;
            btn_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lives_q <= lives_d;
            homes_q <= homes_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_s;
        end
    end

    // Next-state and game datapath; the death counter defaults to zero so it is clear on DYING entry.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        lives_d     = lives_q;
        homes_d     = homes_q;
        score_d     = score_q;
        cnt_d       = '0;
        tgt_col_s   = col_q;
        tgt_row_s   = row_q;
        moved_s     = 1'b0;
        sc_s        = score_q;
        hidx_s      = 3'd0;
        new_homes_s = homes_q;
        case (state_q)
            S_IDLE: begin
                if (edge_s != 4'd0) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_W;
                    homes_d = 5'd0;
                    score_d = 8'd0;
                    col_d   = START_C;
                    row_d   = START_R;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (refresh_tick && hazard) begin
                    lives_d = dec_life(lives_q);
                    state_d = S_DYING;
                end else if (refresh_tick) begin
                    case (pend_q)
                        MV_UP: begin
                            if (row_q != 4'd0) begin
                                tgt_row_s = row_q - 4'd1;
                                moved_s   = 1'b1;
                                sc_s      = sat_add(score_q, 8'd1);
                            end else begin
                                moved_s = 1'b0;
                            end
                        end
                        MV_DOWN: begin
                            if (row_q != START_R) begin
                                tgt_row_s = row_q + 4'd1;
                                moved_s   = 1'b1;
                            end else begin
                                moved_s = 1'b0;
                            end
                        end
                        MV_LEFT: begin
                            if (col_q != 5'd0) begin
                                tgt_col_s = col_q - 5'd1;
                                moved_s   = 1'b1;
                            end else begin
                                moved_s = 1'b0;
                            end
                        end
                        MV_RIGHT: begin
                            if (col_q != LAST_COL) begin
                                tgt_col_s = col_q + 5'd1;
                                moved_s   = 1'b1;
                            end else begin
                                moved_s = 1'b0;
                            end
                        end
                        default: moved_s = 1'b0;
                    endcase
                    col_d       = tgt_col_s;
                    row_d       = tgt_row_s;
                    score_d     = sc_s;
                    hidx_s      = tgt_col_s[4:2];
                    new_homes_s = homes_q | (5'd1 << hidx_s);
                    // Home i spans cols 4i and 4i+1; cols 4i+2 and 4i+3 are wall.
                    if (moved_s && (tgt_row_s == 4'd0)) begin
                        if (!tgt_col_s[1] && !homes_q[hidx_s]) begin
                            homes_d = new_homes_s;
                            score_d = sat_add(sc_s, 8'd10);
                            if (new_homes_s == 5'b11111) begin
                                state_d = S_WON;
                            end else begin
                                col_d = START_C;
                                row_d = START_R;
                            end
                        end else begin
                            lives_d = dec_life(lives_q);
                            state_d = S_DYING;
                        end
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_DYING: begin
                if (refresh_tick && (cnt_q == CNT_LAST)) begin
                    if (lives_q == 2'd0) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_PLAY;
                        col_d   = START_C;
                        row_d   = START_R;
                    end
                end else if (refresh_tick) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WON, S_OVER: begin
                if (edge_s != 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending move: a fresh edge always wins, even over the consume on a tick.
    always_comb begin
        if (state_q != S_PLAY) begin
            pend_d = MV_NONE;
        end else if (edge_s != 4'd0) begin
            pend_d = edge_mv_s;
        end else if (refresh_tick) begin
            pend_d = MV_NONE;
        end else begin
            pend_d = pend_q;
        end
    end

    // Status flags decoded from the registered state.
    always_comb begin
        frog_dead = 1'b0;
        game_won  = 1'b0;
        game_over = 1'b0;
        case (state_q)
            S_DYING: frog_dead = 1'b1;
            S_WON:   game_won  = 1'b1;
            S_OVER:  game_over = 1'b1;
            default: frog_dead = 1'b0;
        endcase
    end

    assign frog_x       = TILE_W + TILE_W * {5'd0, col_q};
    assign frog_y       = 10'd36 + TILE_W * {6'd0, row_q};
    assign homes_filled = homes_q;
    assign lives        = lives_q;
    assign score        = score_q;
endmodule

// File: tb/tb_frog_ctrl.sv
// Bench for frog_ctrl: a game-rule model checked every cycle plus hand-computed
// expectations at key points of a directed play-through.
module tb_frog_ctrl;
    logic       clk = 1'b0;
    logic       reset, refresh_tick, hazard;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [9:0] frog_x, frog_y;
    logic [4:0] homes_filled;
    logic [1:0] lives;
    logic [7:0] score;
    logic       frog_dead, game_won, game_over;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001, NB = 4'b0000;
    localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_WON = 3, M_OVER = 4;

    int         m_st, m_col, m_row, m_lives, m_homes, m_score, m_dticks, m_pend;
    logic [3:0] m_prev;

    frog_ctrl dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .refresh_tick(refresh_tick),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .hazard      (hazard),
        .frog_x      (frog_x),
        .frog_y      (frog_y),
        .homes_filled(homes_filled),
        .lives       (lives),
        .score       (score),
        .frog_dead   (frog_dead),
        .game_won    (game_won),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int lose_life(input int l);
        return (l > 0) ? l - 1 : 0;
    endfunction

    // Game rules applied to the inputs the next rising edge will sample.
    task automatic model_step();
        logic [3:0] b, e;
        int mv, nc, nr, h, old_st;
        if (reset) begin
            m_st = M_IDLE; m_col = 9; m_row = 12; m_lives = 3; m_homes = 0;
            m_score = 0; m_dticks = 0; m_pend = 0; m_prev = 4'd0;
            return;
        end
        b = {btn_up, btn_down, btn_left, btn_right};
        e = b & ~m_prev;
        m_prev = b;
        mv = e[3] ? 1 : e[2] ? 2 : e[1] ? 3 : e[0] ? 4 : 0;
        old_st = m_st;
        case (m_st)
            M_IDLE: if (e != 4'd0) begin
                m_st = M_PLAY; m_lives = 3; m_homes = 0; m_score = 0; m_col = 9; m_row = 12;
            end
            M_PLAY: if (refresh_tick) begin
                if (hazard) begin
                    m_lives = lose_life(m_lives); m_st = M_DYING; m_dticks = 0;
                end else if (m_pend != 0) begin
                    nc = m_col; nr = m_row;
                    if (m_pend == 1) nr = nr - 1;
                    if (m_pend == 2) nr = nr + 1;
                    if (m_pend == 3) nc = nc - 1;
                    if (m_pend == 4) nc = nc + 1;
                    if (nc >= 0 && nc <= 17 && nr >= 0 && nr <= 12) begin
                        m_col = nc; m_row = nr;
                        if (m_pend == 1) m_score = sat(m_score + 1);
                        if (m_row == 0) begin
                            h = m_col / 4;
                            if ((m_col % 4) < 2 && ((m_homes >> h) & 1) == 0) begin
                                m_homes = m_homes | (1 << h);
                                m_score = sat(m_score + 10);
                                if (m_homes == 31) m_st = M_WON;
                                else begin m_col = 9; m_row = 12; end
                            end else begin
                                m_lives = lose_life(m_lives); m_st = M_DYING; m_dticks = 0;
                            end
                        end
                    end
                end
            end
            M_DYING: if (refresh_tick) begin
                m_dticks++;
                if (m_dticks == 60) begin
                    if (m_lives == 0) m_st = M_OVER;
                    else begin m_st = M_PLAY; m_col = 9; m_row = 12; end
                end
            end
            default: if (e != 4'd0) m_st = M_IDLE;
        endcase
        if (old_st != M_PLAY) m_pend = 0;
        else if (e != 4'd0) m_pend = mv;
        else if (refresh_tick) m_pend = 0;
    endtask

    // Every-cycle comparison against the model, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 1) begin
                check("cmp_frog_x", int'(frog_x), 32 + 32 * m_col);
                check("cmp_frog_y", int'(frog_y), 36 + 32 * m_row);
                check("cmp_homes", int'(homes_filled), m_homes);
                check("cmp_lives", int'(lives), m_lives);
                check("cmp_score", int'(score), m_score);
                check("cmp_flags", int'({frog_dead, game_won, game_over}),
                      (m_st == M_DYING ? 4 : 0) + (m_st == M_WON ? 2 : 0) + (m_st == M_OVER ? 1 : 0));
            end
            model_step();
        end
    end

    task automatic step(input logic [3:0] b, input logic t, input logic h);
        {btn_up, btn_down, btn_left, btn_right} = b;
        refresh_tick = t;
        hazard = h;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        step(b, 1'b0, 1'b0);
        step(NB, 1'b0, 1'b0);
    endtask

    task automatic tick();
        step(NB, 1'b1, 1'b0);
        step(NB, 1'b0, 1'b0);
    endtask

    task automatic move(input logic [3:0] b, input int n);
        repeat (n) begin
            press(b);
            tick();
        end
    endtask

    task automatic wait_dying(input string name);
        int n = 0;
        while (frog_dead && n < 100) begin
            tick();
            n++;
        end
        check(name, n, 60);
    endtask

    initial begin
        reset = 1'b1;
        step(NB, 1'b0, 1'b0);
        step(NB, 1'b0, 1'b0);
        check("rst_x", int'(frog_x), 320);
        check("rst_y", int'(frog_y), 420);
        check("rst_lives", int'(lives), 3);
        check("rst_score", int'(score), 0);
        check("rst_flags", int'({frog_dead, game_won, game_over}), 0);
        reset = 1'b0;

        press(UP);
        tick();
        check("start_pos", int'({frog_x, frog_y}), (320 << 10) | 420);
        check("start_lives", int'(lives), 3);
        move(UP, 1);
        check("first_up_y", int'(frog_y), 388);
        check("first_up_score", int'(score), 1);
        move(DN, 2);
        check("down_floor_y", int'(frog_y), 420);
        move(LF, 12);
        check("left_wall_x", int'(frog_x), 32);
        check("left_wall_score", int'(score), 1);

        move(RT, 8);
        move(UP, 12);
        check("home2_bits", int'(homes_filled), 5'b00100);
        check("home2_score", int'(score), 23);
        check("home2_respawn", int'({frog_x, frog_y}), (320 << 10) | 420);

        move(UP, 12);
        check("refill_dead", int'(frog_dead), 1);
        check("refill_y", int'(frog_y), 36);
        check("refill_lives", int'(lives), 2);
        wait_dying("death_ticks_1");
        check("after_death_pos", int'({frog_x, frog_y}), (320 << 10) | 420);

        press(UP);
        step(NB, 1'b1, 1'b1);
        step(NB, 1'b0, 1'b0);
        check("hazard_lives", int'(lives), 1);
        check("hazard_y", int'(frog_y), 420);
        wait_dying("death_ticks_2");
        tick();
        check("discard_y", int'(frog_y), 420);
        step(NB, 1'b1, 1'b1);
        step(NB, 1'b0, 1'b0);
        wait_dying("death_ticks_3");
        check("over_flag", int'(game_over), 1);
        check("over_lives", int'(lives), 0);
        press(LF);
        check("over_to_idle", int'(game_over), 0);

        press(UP);
        check("newgame_lives", int'(lives), 3);
        move(LF, 9);  move(UP, 12);
        move(LF, 5);  move(UP, 12);
        move(LF, 1);  move(UP, 12);
        move(RT, 3);  move(UP, 12);
        check("four_homes", int'(homes_filled), 5'b01111);
        check("four_homes_score", int'(score), 88);
        repeat (180) begin
            move(UP, 1);
            move(DN, 1);
        end
        check("score_clamp", int'(score), 255);
        move(RT, 7);
        move(UP, 11);
        press(UP);
        check("won_before", int'(game_won), 0);
        step(NB, 1'b1, 1'b0);
        check("won_after", int'(game_won), 1);
        check("won_homes", int'(homes_filled), 5'b11111);
        step(NB, 1'b0, 1'b0);
        press(DN);
        check("won_to_idle", int'(game_won), 0);

        press(UP);
        step(UP, 1'b1, 1'b0);
        step(NB, 1'b0, 1'b0);
        check("coinc_same_tick_y", int'(frog_y), 420);
        tick();
        check("coinc_next_tick_y", int'(frog_y), 388);
        move(RT, 9);
        check("right_edge_x", int'(frog_x), 576);

        step(NB, 1'b1, 1'b1);
        step(NB, 1'b0, 1'b0);
        check("dying_before_reset", int'(frog_dead), 1);
        tick();
        press(RT);
        reset = 1'b1;
        step(NB, 1'b0, 1'b0);
        check("midreset_pos", int'({frog_x, frog_y}), (320 << 10) | 420);
        check("midreset_lives", int'(lives), 3);
        check("midreset_score", int'(score), 0);
        check("midreset_flags", int'({frog_dead, game_won, game_over}), 0);
        reset = 1'b0;
        step(NB, 1'b0, 1'b0);
        step(NB, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
